// File: rtl/ex_operand_stage.sv
// Operand-select pipeline register in front of the ALU: captures one decoded
// instruction from ID, holds it across stalls and forwards MEM/WB results.

package ex_operand_pkg;
    typedef enum logic [3:0] {
        ALU_DEFAULT = 4'd0,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_enum;
endpackage

module ex_operand_stage
    import ex_operand_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  alu_op_enum      id_alu_op,
    input  logic [1:0]      id_asel,
    input  logic            id_bsel,
    input  logic            id_we_reg,
    input  logic            fwd_mem_we,
    input  logic [RW-1:0]   fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [RW-1:0]   fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output alu_op_enum      alu_op,
    output logic [XLEN-1:0] ex_pc,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_we_reg,
    output logic [XLEN-1:0] ex_store_data
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic [XLEN-1:0] r_r1;
    logic [XLEN-1:0] r_r2;
    logic [XLEN-1:0] r_imm;
    alu_op_enum      r_alu_op;
    logic [1:0]      r_asel;
    logic            r_bsel;
    logic            r_we_reg;

    logic            w_load;
    logic            w_xfer;
    logic            w_hold;
    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // MEM is younger than WB, so it wins; x0 never forwards.
    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0]   rs,
                                            input logic [XLEN-1:0] q);
        if (fwd_mem_we && fwd_mem_rd == rs && rs != '0)
            return fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == rs && rs != '0)
            return fwd_wb_data;
        else
            return q;
    endfunction

    assign id_ready  = !r_valid || ex_ready;
    assign w_load    = id_valid && id_ready;
    assign w_xfer    = r_valid && ex_ready;
    assign w_hold    = r_valid && !ex_ready && !flush;
    assign w_wb_hit1 = fwd_wb_we && fwd_wb_rd == r_rs1 && r_rs1 != '0;
    assign w_wb_hit2 = fwd_wb_we && fwd_wb_rd == r_rs2 && r_rs2 != '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_r1     <= '0;
            r_r2     <= '0;
            r_imm    <= '0;
            r_alu_op <= ALU_DEFAULT;
            r_asel   <= '0;
            r_bsel   <= 1'b0;
            r_we_reg <= 1'b0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (w_load)
                r_valid <= 1'b1;
            else if (w_xfer)
                r_valid <= 1'b0;

            if (w_load && !flush) begin
                r_pc     <= id_pc;
                r_rs1    <= id_rs1;
                r_rs2    <= id_rs2;
                r_rd     <= id_rd;
                r_r1     <= id_rs1_data;
                r_r2     <= id_rs2_data;
                r_imm    <= id_imm;
                r_alu_op <= id_alu_op;
                r_asel   <= id_asel;
                r_bsel   <= id_bsel;
                r_we_reg <= id_we_reg;
            end else if (w_hold) begin
                // A retiring WB producer would otherwise vanish during the stall.
                if (w_wb_hit1)
                    r_r1 <= fwd_wb_data;
                if (w_wb_hit2)
                    r_r2 <= fwd_wb_data;
            end
        end
    end

    assign w_op1 = fwd(r_rs1, r_r1);
    assign w_op2 = fwd(r_rs2, r_r2);

    always_comb begin
        alu_a = '0;
        case (r_asel)
            2'd0:    alu_a = w_op1;
            2'd1:    alu_a = r_pc;
            default: alu_a = '0;
        endcase
    end

    assign alu_b         = r_bsel ? r_imm : w_op2;
    assign ex_store_data = w_op2;
    assign alu_op        = r_valid ? r_alu_op : ALU_DEFAULT;
    assign ex_we_reg     = r_valid && r_we_reg;
    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rd         = r_rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: scoreboard of expected EX outputs
// pushed on accept and compared when the stage presents the instruction.

module tb_ex_operand_stage;
    import ex_operand_pkg::*;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic [RW-1:0]   id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    alu_op_enum      id_alu_op;
    logic [1:0]      id_asel;
    logic            id_bsel;
    logic            id_we_reg;
    logic            fwd_mem_we;
    logic [RW-1:0]   fwd_mem_rd;
    logic [XLEN-1:0] fwd_mem_data;
    logic            fwd_wb_we;
    logic [RW-1:0]   fwd_wb_rd;
    logic [XLEN-1:0] fwd_wb_data;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    alu_op_enum      alu_op;
    logic [XLEN-1:0] ex_pc;
    logic [RW-1:0]   ex_rd;
    logic            ex_we_reg;
    logic [XLEN-1:0] ex_store_data;

    ex_operand_stage #(.XLEN(XLEN), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_asel(id_asel), .id_bsel(id_bsel),
        .id_we_reg(id_we_reg),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_we_reg(ex_we_reg), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] st;
        logic [XLEN-1:0] pc;
        logic [RW-1:0]   rd;
        logic            we;
        alu_op_enum      op;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_id(input logic [XLEN-1:0] pc, input logic [RW-1:0] rs1,
                            input logic [RW-1:0] rs2, input logic [RW-1:0] rd,
                            input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                            input logic [XLEN-1:0] imm, input alu_op_enum op,
                            input logic [1:0] asel, input logic bsel, input logic we);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_alu_op   = op;
        id_asel     = asel;
        id_bsel     = bsel;
        id_we_reg   = we;
    endtask

    task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] st, input logic [XLEN-1:0] pc,
                        input logic [RW-1:0] rd, input logic we, input alu_op_enum op);
        exp_t e;
        e.a = a; e.b = b; e.st = st; e.pc = pc; e.rd = rd; e.we = we; e.op = op;
        sb.push_back(e);
    endtask

    task automatic clear_fwd();
        fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = '0; fwd_wb_data  = '0;
    endtask

    // Compare the presented instruction against the scoreboard head; pop=1 when it leaves.
    task automatic expect_out(input string tag, input bit pop);
        exp_t e;
        check({tag, ".ex_valid"}, 64'(ex_valid), 64'd1);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb[0];
        check({tag, ".alu_a"}, alu_a, e.a);
        check({tag, ".alu_b"}, alu_b, e.b);
        check({tag, ".store"}, ex_store_data, e.st);
        check({tag, ".pc"}, ex_pc, e.pc);
        check({tag, ".rd"}, 64'(ex_rd), 64'(e.rd));
        check({tag, ".we"}, 64'(ex_we_reg), 64'(e.we));
        check({tag, ".op"}, 64'(alu_op), 64'(e.op));
        if (pop)
            void'(sb.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ex_valid"}, 64'(ex_valid), 64'd0);
        check({tag, ".id_ready"}, 64'(id_ready), 64'd1);
        check({tag, ".alu_a"}, alu_a, 64'd0);
        check({tag, ".alu_b"}, alu_b, 64'd0);
        check({tag, ".alu_op"}, 64'(alu_op), 64'(ALU_DEFAULT));
        check({tag, ".ex_pc"}, ex_pc, 64'd0);
        check({tag, ".ex_rd"}, 64'(ex_rd), 64'd0);
        check({tag, ".ex_we_reg"}, 64'(ex_we_reg), 64'd0);
        check({tag, ".store"}, ex_store_data, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XLEN-1:0] pc, d1, d2, imm, ea, eb;
        logic [1:0]      asel;
        logic            bsel;

        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
        drive_id('0, '0, '0, '0, '0, '0, '0, ALU_DEFAULT, 2'd0, 1'b0, 1'b0);
        id_valid = 1'b0;
        clear_fwd();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic accept, 1-cycle latency.
        drive_id(64'h1000, 5'd1, 5'd2, 5'd4, 64'd5, 64'd7, 64'd0, ALU_ADD, 2'd0, 1'b0, 1'b1);
        push(64'd5, 64'd7, 64'd7, 64'h1000, 5'd4, 1'b1, ALU_ADD);
        @(negedge clk);
        id_valid = 1'b0;
        check("basic.id_ready", 64'(id_ready), 64'd1);
        expect_out("basic", 1'b1);

        // Forwarding priority on a held instruction.
        @(negedge clk);
        check("drain.ex_valid", 64'(ex_valid), 64'd0);
        ex_ready = 1'b0;
        drive_id(64'h2000, 5'd3, 5'd6, 5'd7, 64'h11, 64'h22, 64'h99, ALU_SUB, 2'd0, 1'b1, 1'b1);
        push(64'h11, 64'h99, 64'h22, 64'h2000, 5'd7, 1'b1, ALU_SUB);
        @(negedge clk);
        id_valid = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 64'hAA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 64'hBB;
        #1 check("fwd.mem_wins", alu_a, 64'hAA);
        fwd_mem_we = 1'b0;
        #1 check("fwd.wb", alu_a, 64'hBB);
        fwd_wb_we = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd6; fwd_mem_data = 64'hCC;
        #1 check("fwd.rs2_store", ex_store_data, 64'hCC);
        check("fwd.bsel_imm", alu_b, 64'h99);
        clear_fwd();

        // Full stage stalled: ID must be refused, held fields stable.
        drive_id(64'h3000, 5'd8, 5'd9, 5'd10, 64'h100, 64'h200, 64'h0, ALU_XOR, 2'd1, 1'b0, 1'b0);
        #1 check("stall.id_ready", 64'(id_ready), 64'd0);
        @(negedge clk);
        expect_out("stall_hold", 1'b0);
        ex_ready = 1'b1;
        #1 check("release.id_ready", 64'(id_ready), 64'd1);
        push(64'h3000, 64'h200, 64'h200, 64'h3000, 5'd10, 1'b0, ALU_XOR);
        expect_out("release_b", 1'b1);
        @(negedge clk);
        id_valid = 1'b0;
        expect_out("no_bubble_c", 1'b1);
        @(negedge clk);
        check("after_c.ex_valid", 64'(ex_valid), 64'd0);

        // x0 never forwards, also not through hold-refresh.
        ex_ready = 1'b0;
        drive_id(64'h4000, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, ALU_AND, 2'd0, 1'b0, 1'b0);
        push(64'd0, 64'd0, 64'd0, 64'h4000, 5'd0, 1'b0, ALU_AND);
        @(negedge clk);
        id_valid = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 64'hDEAD;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd0; fwd_wb_data  = 64'hBEEF;
        #1 check("x0.alu_a", alu_a, 64'd0);
        @(negedge clk);
        expect_out("x0_held", 1'b0);
        clear_fwd();
        ex_ready = 1'b1;
        expect_out("x0_out", 1'b1);
        @(negedge clk);

        // WB hold-refresh over a 3-cycle stall; MEM must not be latched.
        ex_ready = 1'b0;
        drive_id(64'h5000, 5'd12, 5'd13, 5'd14, 64'h1, 64'h2, 64'h0, ALU_ADD, 2'd0, 1'b0, 1'b1);
        push(64'h1, 64'h55, 64'h55, 64'h5000, 5'd14, 1'b1, ALU_ADD);
        @(negedge clk);
        id_valid = 1'b0;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd13; fwd_wb_data  = 64'h55;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd12; fwd_mem_data = 64'h77;
        #1 check("refresh.comb_b", alu_b, 64'h55);
        @(negedge clk);
        clear_fwd();
        #1 expect_out("refresh_s2", 1'b0);
        @(negedge clk);
        expect_out("refresh_s3", 1'b0);
        ex_ready = 1'b1;
        expect_out("refresh_out", 1'b1);
        @(negedge clk);

        // Back-to-back throughput across all A/B selects.
        for (int i = 0; i < 6; i++) begin
            pc   = 64'h8000 + 64'(i * 4);
            d1   = {$urandom, $urandom};
            d2   = {$urandom, $urandom};
            imm  = {$urandom, $urandom};
            asel = 2'(i);
            bsel = 1'(i);
            ea   = (asel == 2'd0) ? d1 : (asel == 2'd1) ? pc : 64'd0;
            eb   = bsel ? imm : d2;
            drive_id(pc, 5'(i + 1), 5'(i + 17), 5'(i), d1, d2, imm, ALU_OR, asel, bsel, 1'b1);
            push(ea, eb, d2, pc, 5'(i), 1'b1, ALU_OR);
            @(negedge clk);
            check("b2b.id_ready", 64'(id_ready), 64'd1);
            expect_out("b2b", 1'b1);
        end

        // Flush concurrent with a load leaves the stage empty.
        flush = 1'b1;
        drive_id(64'h9000, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3, ALU_SLT, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;
        check("flush_load.ex_valid", 64'(ex_valid), 64'd0);
        check("flush_load.alu_op", 64'(alu_op), 64'(ALU_DEFAULT));
        check("flush_load.we", 64'(ex_we_reg), 64'd0);

        // Flush of a stalled instruction; id_ready stays ungated by flush.
        ex_ready = 1'b0;
        drive_id(64'hA000, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3, ALU_SRA, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        id_valid = 1'b0;
        check("flush_hold.pre", 64'(ex_valid), 64'd1);
        flush = 1'b1;
        #1 check("flush_hold.id_ready", 64'(id_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_hold.ex_valid", 64'(ex_valid), 64'd0);
        check("flush_hold.we", 64'(ex_we_reg), 64'd0);

        // Asynchronous reset in the middle of a stall.
        drive_id(64'hB000, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, ALU_SLL, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        id_valid = 1'b0;
        check("rst_stall.pre", 64'(ex_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        ex_ready = 1'b1;

        check("sb.leftover", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
